serv_rf_ram_clr: RTL

// - Register-file SRAM sitting directly downstream of the serial RF RAM interface: consumes its
//   o_waddr/o_wdata/o_wen/o_raddr/o_ren and returns i_rdata one cycle after a read enable.
// - Adds a post-reset clear sequencer writing zero to every word, so x0..x31 and CSR slots start
//   at 0; o_busy holds the core in reset until the sweep completes.

---
 rtl/serv_rf_ram_clr_pkg.sv | 19 +
 rtl/serv_rf_ram_core.sv | 43 ++++
 rtl/serv_rf_ram_clr.sv | 102 ++++++++++
 3 files changed

// File: rtl/serv_rf_ram_clr_pkg.sv
// Shared definitions for the register-file RAM with post-reset clear.
//   GPR_REGS  : number of general-purpose registers held in the RAM
//   state_t   : sequencer states (CLEAR sweeps zeros, RUN serves the core)
//   rf_depth  : number of width-bit words needed for the GPRs plus CSR slots
package serv_rf_ram_clr_pkg;

    localparam int GPR_REGS = 32;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    // Each register is 32 bits, stored as 32/width consecutive words.
    function automatic int rf_depth(input int width, input int csr_regs);
        return 32 * (GPR_REGS + csr_regs) / width;
    endfunction

endpackage

// File: rtl/serv_rf_ram_core.sv
// Plain 1R1W synchronous RAM array, kept free of reset so a technology
// SRAM macro can be dropped in its place.
//   i_clk           : clock
//   i_waddr/i_wdata : write address/data, written when i_wen is high
//   i_raddr         : read address, captured when i_ren is high
//   o_rdata         : registered read data (read-first on address collision)
// Addresses at or beyond depth are dropped on write and read back as zero.
module serv_rf_ram_core #(
    parameter int width = 8,
    parameter int depth = 128,
    parameter int aw    = 7
) (
    input  logic             i_clk,
    input  logic [aw-1:0]    i_waddr,
    input  logic [width-1:0] i_wdata,
    input  logic             i_wen,
    input  logic [aw-1:0]    i_raddr,
    input  logic             i_ren,
    output logic [width-1:0] o_rdata
);

    localparam logic [aw:0] DEPTH_L = (aw + 1)'(depth);

    logic [width-1:0] mem [0:depth-1];

    logic waddr_ok;
    logic raddr_ok;

    assign waddr_ok = ({1'b0, i_waddr} < DEPTH_L);
    assign raddr_ok = ({1'b0, i_raddr} < DEPTH_L);

    // Both updates are non-blocking, so a read of the word being written
    // in the same cycle returns the previous contents.
    always_ff @(posedge i_clk) begin
        if (i_wen && waddr_ok) begin
            mem[i_waddr] <= i_wdata;
        end
        if (i_ren) begin
            o_rdata <= raddr_ok ? mem[i_raddr] : '0;
        end
    end

endmodule

// File: rtl/serv_rf_ram_clr.sv
// Register-file RAM with a post-reset clear sweep. After reset release the
// sequencer writes zero to every word, one per cycle, holding o_busy high
// until the whole array is cleared; then it serves the RF RAM interface.
//   i_clk, i_rst        : clock, asynchronous active-high reset
//   i_waddr/i_wdata/i_wen : write port
//   i_raddr/i_ren       : read port
//   o_rdata             : read data, one cycle after i_ren, held otherwise
//   o_busy              : clear sweep in progress, RAM ports ignored
module serv_rf_ram_clr
    import serv_rf_ram_clr_pkg::*;
#(
    parameter int width          = 8,
    parameter int csr_regs       = 4,
    parameter int depth          = rf_depth(width, csr_regs),
    parameter int aw             = $clog2(depth),
    parameter int clear_on_reset = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [aw-1:0]    i_waddr,
    input  logic [width-1:0] i_wdata,
    input  logic             i_wen,
    input  logic [aw-1:0]    i_raddr,
    input  logic             i_ren,
    output logic [width-1:0] o_rdata,
    output logic             o_busy
);

    localparam state_t        RESET_STATE = (clear_on_reset != 0) ? CLEAR : RUN;
    localparam logic [aw-1:0] LAST        = aw'(depth - 1);

    state_t           state;
    state_t           state_next;
    logic [aw-1:0]    cnt;
    logic [aw-1:0]    cnt_next;
    logic             busy;

    logic [aw-1:0]    core_waddr;
    logic [width-1:0] core_wdata;
    logic             core_wen;
    logic             core_ren;
    logic [width-1:0] rdata_p1;
    logic             vld_p1;

    assign busy   = (state == CLEAR);
    assign o_busy = busy;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state  <= RESET_STATE;
            cnt    <= '0;
            vld_p1 <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (core_ren) begin
                vld_p1 <= 1'b1;
            end
        end
    end

    // The counter stops at the last word instead of wrapping, so a
    // power-of-two depth never revisits address 0.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        if (state == CLEAR) begin
            if (cnt == LAST) begin
                state_next = RUN;
            end else begin
                cnt_next = cnt + aw'(1);
            end
        end
    end

    always_comb begin
        core_waddr = busy ? cnt : i_waddr;
        core_wdata = busy ? '0 : i_wdata;
        core_wen   = busy | i_wen;
        core_ren   = i_ren & ~busy;
    end

    serv_rf_ram_core #(
        .width (width),
        .depth (depth),
        .aw    (aw)
    ) u_core (
        .i_clk   (i_clk),
        .i_waddr (core_waddr),
        .i_wdata (core_wdata),
        .i_wen   (core_wen),
        .i_raddr (i_raddr),
        .i_ren   (core_ren),
        .o_rdata (rdata_p1)
    );

    // ---- stage p1: registered read data ----
    // The array register has no reset; until the first read after reset it
    // is masked so o_rdata reads zero from reset onward.
    assign o_rdata = vld_p1 ? rdata_p1 : '0;

endmodule
